// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, response entry and issue FSM encoding for alu_issue
package alu_pkg;

  localparam logic [3:0] OP_ARITH = 4'b0000;
  localparam logic [3:0] OP_SHIFT = 4'b0011;
  localparam logic [3:0] OP_CRC   = 4'b1010;
  localparam logic [3:0] OP_MAX   = 4'b1010;

  localparam logic [31:0] ILLEGAL_RESULT = 32'hDEADBEEF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef struct packed {
    logic        err;
    logic        ovf;
    logic [31:0] data;
  } rsp_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// rtl/alu_rsp_fifo.sv - first-word-fall-through response FIFO, head reads zero when empty
module alu_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             valid,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             pop_ok;

  assign pop_ok    = pop && (count != '0);
  assign valid     = (count != '0);
  assign full      = (count == FULL_CNT);
  assign head_data = valid ? mem[rd_ptr] : '0;

  // Storage needs no reset: emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - issues one ALU operation at a time and queues its result with overflow/error flags
module alu_issue
  import alu_pkg::*;
#(
  parameter int TIMEOUT   = 64,
  parameter int RSP_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_opcode,
  input  logic [2:0]  cmd_funct,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        alu_vld_o,
  output logic [3:0]  alu_opcode,
  output logic [2:0]  alu_funct,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_o,
  input  logic        alu_vld_i,
  input  logic        alu_ovf,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_ovf,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] cnt;
  logic       fifo_full;
  logic       push;
  rsp_t       push_entry;
  rsp_t       head;

  assign cmd_ready = (state == ST_IDLE) && !fifo_full;
  assign alu_vld_o = (state == ST_ISSUE);
  assign busy      = (state != ST_IDLE);
  assign rsp_data  = head.data;
  assign rsp_ovf   = head.ovf;
  assign rsp_err   = head.err;

  // A real result arriving on the timeout cycle still wins over the abandon entry.
  always_comb begin
    push       = 1'b0;
    push_entry = '{err: (alu_opcode > OP_MAX),
                   ovf: (alu_ovf && (alu_opcode == OP_ARITH)),
                   data: alu_o};
    case (state)
      ST_ISSUE: push = alu_vld_i;
      ST_WAIT: begin
        push = alu_vld_i || (cnt == CNT_LAST);
        if (!alu_vld_i) push_entry = '{err: 1'b1, ovf: 1'b0, data: ILLEGAL_RESULT};
      end
      default: push = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      alu_opcode <= '0;
      alu_funct  <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            alu_opcode <= cmd_opcode;
            alu_funct  <= cmd_funct;
            alu_a      <= cmd_a;
            alu_b      <= cmd_b;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (alu_vld_i) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_WAIT;
            cnt   <= '0;
          end
        end
        ST_WAIT: begin
          if (push) state <= ST_IDLE;
          else      cnt   <= cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  alu_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (34)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (rsp_valid && rsp_ready),
    .head_data (head),
    .valid     (rsp_valid),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - randomized and directed checks of alu_issue against a transaction-level model
module tb_alu_issue;
  import alu_pkg::*;

  localparam int TIMEOUT   = 64;
  localparam int RSP_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode = '0;
  logic [2:0]  cmd_funct = '0;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic        alu_vld_o;
  logic [3:0]  alu_opcode;
  logic [2:0]  alu_funct;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_o = '0;
  logic        alu_vld_i = 1'b0;
  logic        alu_ovf = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_ovf;
  logic        rsp_err;
  logic        busy;

  alu_issue #(.TIMEOUT(TIMEOUT), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_funct(cmd_funct), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_vld_o(alu_vld_o), .alu_opcode(alu_opcode), .alu_funct(alu_funct),
    .alu_a(alu_a), .alu_b(alu_b), .alu_o(alu_o), .alu_vld_i(alu_vld_i), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_acc = 0;

  // Model of the one outstanding operation and the operand registers.
  bit          inflight = 0;
  int          acc_c = -10;
  int          d_cur = 0;
  logic [3:0]  m_op = '0;
  logic [2:0]  m_fn = '0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [31:0] r_o = '0;
  logic        r_ovf = 1'b0;

  bit          k_valid = 0, k_rst = 0, k_rsp_ready = 0, k_spur = 0, k_ovf = 0;
  logic [3:0]  k_op = '0;
  logic [2:0]  k_fn = '0;
  logic [31:0] k_a = '0, k_b = '0;
  int          k_d = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Result is pushed on the ALU's valid cycle, or after TIMEOUT WAIT cycles at the latest.
  function automatic int push_cycle();
    return acc_c + 1 + ((d_cur < TIMEOUT) ? d_cur : TIMEOUT);
  endfunction

  task automatic step();
    bit   exp_ready;
    exp_t e;
    exp_ready = !inflight && (q.size() < RSP_DEPTH);
    chk("cmd_ready", cmd_ready, exp_ready);
    chk("busy", busy, inflight);
    chk("alu_vld_o", alu_vld_o, inflight && (cyc == acc_c + 1));
    chk("alu_opcode", alu_opcode, m_op);
    chk("alu_funct", alu_funct, m_fn);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("rsp_valid", rsp_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("rsp_data", rsp_data, q[0].data);
      chk("rsp_ovf", rsp_ovf, q[0].ovf);
      chk("rsp_err", rsp_err, q[0].err);
    end else begin
      chk("rsp_data_empty", rsp_data, 0);
      chk("rsp_flags_empty", {rsp_ovf, rsp_err}, 0);
    end

    rst = k_rst;
    cmd_valid = k_valid;
    cmd_opcode = k_op;
    cmd_funct = k_fn;
    cmd_a = k_a;
    cmd_b = k_b;
    rsp_ready = k_rsp_ready;
    if (inflight && (cyc == acc_c + 1 + d_cur)) begin
      r_o = m_a + m_b;
      r_ovf = k_ovf;
      alu_vld_i = 1'b1;
      alu_o = r_o;
      alu_ovf = r_ovf;
    end else begin
      alu_vld_i = !inflight && k_spur;
      alu_o = $urandom;
      alu_ovf = 1'($urandom_range(0, 1));
    end

    @(posedge clk);
    if (k_rst) begin
      q.delete();
      inflight = 0;
      m_op = '0; m_fn = '0; m_a = '0; m_b = '0;
    end else begin
      if (q.size() > 0 && k_rsp_ready) q.delete(0);
      if (inflight && (cyc == push_cycle())) begin
        if (d_cur <= TIMEOUT) e = '{r_o, r_ovf && (m_op == 4'd0), m_op > 4'd10};
        else                  e = '{32'hDEADBEEF, 1'b0, 1'b1};
        q.push_back(e);
        inflight = 0;
      end
      if (k_valid && exp_ready) begin
        inflight = 1;
        acc_c = cyc;
        d_cur = k_d;
        m_op = k_op; m_fn = k_fn; m_a = k_a; m_b = k_b;
        n_acc++;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic quiet();
    k_valid = 0; k_rst = 0; k_spur = 0; k_rsp_ready = 1; k_ovf = 0;
  endtask

  task automatic drain();
    int n;
    quiet();
    n = 0;
    while ((inflight || q.size() > 0) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("drain_bound", 1, 0);
  endtask

  task automatic issue_one(logic [3:0] op, logic [31:0] a, logic [31:0] b, int d);
    int start, n;
    k_valid = 1; k_op = op; k_fn = 3'd2; k_a = a; k_b = b; k_d = d;
    start = n_acc;
    n = 0;
    while (n_acc == start && n < 200) begin
      step();
      n++;
    end
    k_valid = 0;
    if (n_acc == start) chk("issue_bound", 0, 1);
  endtask

  task automatic randomize_knobs();
    k_valid = ($urandom_range(0, 9) < 6);
    k_op = 4'($urandom_range(0, 15));
    k_fn = 3'($urandom_range(0, 7));
    k_a = $urandom;
    k_b = $urandom;
    k_rsp_ready = ($urandom_range(0, 3) != 0);
    k_spur = ($urandom_range(0, 3) == 0);
    k_ovf = 1'($urandom_range(0, 1));
    k_rst = ($urandom_range(0, 499) == 0);
    case ($urandom_range(0, 29))
      0:       k_d = TIMEOUT - 1;
      1:       k_d = TIMEOUT;
      2:       k_d = TIMEOUT + 1;
      3:       k_d = 1000;
      default: k_d = $urandom_range(0, 4);
    endcase
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nb, nv;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_alu_a", alu_a, 0);
    quiet();

    // Same-cycle arithmetic result with overflow.
    k_rsp_ready = 0; k_ovf = 1;
    issue_one(OP_ARITH, 32'h7FFFFFFF, 32'h1, 0);
    chk("lat_issue_vld", alu_vld_o, 1);
    chk("lat_not_yet", rsp_valid, 0);
    step();
    chk("arith_valid", rsp_valid, 1);
    chk("arith_data", rsp_data, 32'h80000000);
    chk("arith_ovf", rsp_ovf, 1);
    chk("arith_err", rsp_err, 0);

    // Result 5 cycles after ISSUE.
    drain();
    issue_one(OP_SHIFT, 32'h11, 32'h22, 5);
    nb = 0; nv = 0;
    repeat (10) begin
      nb += busy;
      nv += alu_vld_o;
      step();
    end
    chk("slow_busy_cycles", nb, 6);
    chk("slow_vld_pulses", nv, 1);

    // ALU never answers: abandon entry.
    drain();
    k_rsp_ready = 0;
    issue_one(OP_SHIFT, 32'h1, 32'h2, 1000);
    k = 1;
    while (!rsp_valid && k < 200) begin
      step();
      k++;
    end
    chk("timeout_latency", k, 66);
    chk("timeout_data", rsp_data, 32'hDEADBEEF);
    chk("timeout_flags", {rsp_ovf, rsp_err}, 2'b01);

    // Back-pressure with a full response FIFO.
    drain();
    k_rsp_ready = 0;
    issue_one(4'd1, 32'd10, 32'd0, 0);
    issue_one(4'd1, 32'd20, 32'd0, 0);
    k_valid = 1; k_op = 4'd1; k_a = 32'd30; k_b = 32'd0; k_d = 0;
    repeat (4) step();
    chk("full_cmd_ready", cmd_ready, 0);
    chk("full_head", rsp_data, 32'd10);
    k_rsp_ready = 1;
    step();
    chk("pop_order_2", rsp_data, 32'd20);
    step();
    k_valid = 0;
    step();
    chk("pop_order_3", rsp_data, 32'd30);

    // Illegal opcode, and overflow masked on non-arith opcode.
    drain();
    k_rsp_ready = 0;
    issue_one(4'hF, 32'h5, 32'h6, 0);
    step();
    chk("illegal_err", rsp_err, 1);
    chk("illegal_data", rsp_data, 32'hB);
    drain();
    k_rsp_ready = 0; k_ovf = 1;
    issue_one(4'h5, 32'h5, 32'h6, 0);
    step();
    chk("ovf_masked", {rsp_valid, rsp_ovf, rsp_err}, 3'b100);

    // Reset in WAIT, then a late ALU valid.
    drain();
    issue_one(OP_SHIFT, 32'h9, 32'h9, 1000);
    repeat (4) step();
    k_rst = 1;
    step();
    k_rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_alu_a", alu_a, 0);
    k_spur = 1;
    repeat (3) step();
    chk("late_vld_ignored", rsp_valid, 0);

    repeat (3000) begin
      randomize_knobs();
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
